// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants and the writeback source encoding for the writeback scheduler.
package regfile_wb_scheduler_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 2 ** REG_ADDR_W;

  // Source 0 is the single-cycle ALU path, source 1 the multi-cycle load/MUL path.
  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Writeback request bundle for the two sources feeding the register file write port.
interface regfile_wb_scheduler_if;
  import regfile_wb_scheduler_pkg::*;

  logic                  wb0_valid;
  logic [REG_ADDR_W-1:0] wb0_rd;
  logic [XLEN-1:0]       wb0_data;
  logic                  wb0_ready;

  logic                  wb1_valid;
  logic [REG_ADDR_W-1:0] wb1_rd;
  logic [XLEN-1:0]       wb1_data;
  logic                  wb1_ready;

  // Writeback sources drive the requests.
  modport master (
    output wb0_valid, wb0_rd, wb0_data,
    output wb1_valid, wb1_rd, wb1_data,
    input  wb0_ready, wb1_ready
  );

  // The scheduler accepts the requests.
  modport slave (
    input  wb0_valid, wb0_rd, wb0_data,
    input  wb1_valid, wb1_rd, wb1_data,
    output wb0_ready, wb1_ready
  );

endinterface

// File: rtl/regfile_wb_scheduler_rr_arbiter2.sv
// Two-requester round-robin arbiter; grant is combinational, last_grant moves only on a grant.
module regfile_wb_scheduler_rr_arbiter2
  import regfile_wb_scheduler_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  wb_src_e    r_last_grant;
  wb_src_e    w_last_grant_d;
  logic [1:0] w_gnt;

  // Last-grant register; reset to LSU so the ALU wins the first tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last_grant <= WB_SRC_LSU;
    end else begin
      r_last_grant <= w_last_grant_d;
    end
  end

  // Every grant is a transfer because grant only rises with its request.
  always_comb begin
    w_last_grant_d = r_last_grant;
    if (w_gnt[0]) begin
      w_last_grant_d = WB_SRC_ALU;
    end else if (w_gnt[1]) begin
      w_last_grant_d = WB_SRC_LSU;
    end
  end

  // Grant decode: a lone requester wins, a tie goes to the source not granted last.
  always_comb begin
    w_gnt = 2'b00;
    unique case (i_req)
      2'b01:   w_gnt = 2'b01;
      2'b10:   w_gnt = 2'b10;
      2'b11:   w_gnt = (r_last_grant == WB_SRC_ALU) ? 2'b10 : 2'b01;
      default: w_gnt = 2'b00;
    endcase
  end

  assign o_gnt = w_gnt;

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates two writeback sources onto the register file write port through one
// registered stage and tracks a per-register busy scoreboard for RAW/WAW hazards.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  regfile_wb_scheduler_if.slave   wb,
  input  logic                    issue_valid,
  input  logic [REG_ADDR_W-1:0]   issue_rd,
  output logic                    issue_ready,
  input  logic [REG_ADDR_W-1:0]   rs1_addr,
  input  logic [REG_ADDR_W-1:0]   rs2_addr,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  output logic                    regwrite,
  output logic [REG_ADDR_W-1:0]   write_reg,
  output logic [XLEN-1:0]         write_data
);

  logic [1:0]            w_req;
  logic [1:0]            w_gnt;
  logic                  w_xfer;
  logic [REG_ADDR_W-1:0] w_sel_rd;
  logic [XLEN-1:0]       w_sel_data;
  logic                  w_wr_en;
  logic                  w_issue_fire;
  logic [NUM_REGS-1:0]   w_busy_d;

  logic [NUM_REGS-1:0]   r_busy;
  logic                  r_regwrite;
  logic [REG_ADDR_W-1:0] r_write_reg;
  logic [XLEN-1:0]       r_write_data;

  assign w_req = {wb.wb1_valid, wb.wb0_valid};

  regfile_wb_scheduler_rr_arbiter2 u_arb (
    .clock (clock),
    .reset (reset),
    .i_req (w_req),
    .o_gnt (w_gnt)
  );

  assign wb.wb0_ready = w_gnt[0];
  assign wb.wb1_ready = w_gnt[1];
  assign w_xfer       = |w_gnt;
  assign w_sel_rd     = w_gnt[1] ? wb.wb1_rd   : wb.wb0_rd;
  assign w_sel_data   = w_gnt[1] ? wb.wb1_data : wb.wb0_data;
  // x0 writebacks are consumed but never reach the register file.
  assign w_wr_en      = w_xfer && (w_sel_rd != '0);

  assign issue_ready  = !r_busy[issue_rd];
  assign w_issue_fire = issue_valid && issue_ready && (issue_rd != '0);
  assign rs1_busy     = r_busy[rs1_addr];
  assign rs2_busy     = r_busy[rs2_addr];

  // Scoreboard next state: clear on the register file write, then set, so set wins.
  always_comb begin
    w_busy_d = r_busy;
    if (r_regwrite) begin
      w_busy_d[r_write_reg] = 1'b0;
    end
    if (w_issue_fire) begin
      w_busy_d[issue_rd] = 1'b1;
    end
    w_busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_d;
    end
  end

  // Output stage: one cycle of latency; address/data hold when nothing is written.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_regwrite   <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else begin
      r_regwrite <= w_wr_en;
      if (w_wr_en) begin
        r_write_reg  <= w_sel_rd;
        r_write_data <= w_sel_data;
      end
    end
  end

  assign regwrite   = r_regwrite;
  assign write_reg  = r_write_reg;
  assign write_data = r_write_data;

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Sits between two writeback sources and the 32x32 register file's single write port.
- Source 0 is the single-cycle ALU path; source 1 is the multi-cycle load/MUL path.
- Arbitrates writebacks round-robin and drives the register file's regwrite/write_reg/write_data through one registered stage.
- Keeps a per-register busy scoreboard so decode can stall on RAW hazards and block WAW issue.

Parameters:
- XLEN, 32, data width of a register.
- REG_ADDR_W, 5, register index width.
- NUM_REGS, 32, number of architectural registers (2**REG_ADDR_W).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- issue_valid  in  1  decode issues an instruction that will write issue_rd.
- issue_rd  in  REG_ADDR_W  destination register of the issuing instruction.
- issue_ready  out  1  low when issue_rd is already busy (WAW block).
- rs1_addr  in  REG_ADDR_W  source register 1 of the instruction in decode.
- rs2_addr  in  REG_ADDR_W  source register 2 of the instruction in decode.
- rs1_busy  out  1  rs1_addr has a pending write.
- rs2_busy  out  1  rs2_addr has a pending write.
- wb0_valid, wb1_valid  in  1  writeback request from source 0 / source 1.
- wb0_rd, wb1_rd  in  REG_ADDR_W  writeback destination.
- wb0_data, wb1_data  in  XLEN  writeback data.
- wb0_ready, wb1_ready  out  1  request accepted this cycle.
- regwrite  out  1  to the register file write enable.
- write_reg  out  REG_ADDR_W  to the register file write address.
- write_data  out  XLEN  to the register file write data.

Behaviour:
- Reset is asynchronous and active-high; all state clears immediately:
  - regwrite=0, write_reg=0, write_data=0.
  - busy[]=0; last_grant=1, so source 0 wins the first tie.
  - Combinational outputs follow the cleared state.
- Handshake:
  - A source holds valid/rd/data stable until it sees ready.
  - Transfer occurs when valid&&ready at a rising edge.
  - wbN_ready is combinational from the valid inputs and last_grant.
  - At most one ready is high per cycle.
- Arbitration:
  - With one valid requester, that requester is granted.
  - With both valid, grant goes to the source not equal to last_grant.
  - last_grant updates only on a transfer.
  - With no valid requester, there is no grant and last_grant holds.
- Output stage, fixed 1-cycle latency:
  - A transfer at edge t drives regwrite=1 with the granted rd/data during cycle t+1.
  - The register file captures the value at edge t+1.
  - With no transfer, the next regwrite=0; write_reg/write_data hold their previous values.
- x0 writeback:
  - A transfer with rd=0 is accepted (ready asserted) and consumed.
  - regwrite stays 0 and busy is unaffected.
- Scoreboard:
  - busy[r] sets at the edge where issue_valid && issue_ready && issue_rd=r && r!=0.
  - busy[r] clears at the edge where the output stage is writing r (regwrite=1, write_reg=r), i.e. the same edge the register file is written.
  - busy[0] is constant 0.
  - Set and clear of the same register on the same edge: set wins.
- Hazard outputs (combinational):
  - rsN_busy = busy[rsN_addr].
  - No bypass; decode stalls while busy.
  - Once busy drops, the register file already holds the new value, so the next read is correct.
- issue_ready = !busy[issue_rd]; it is always 1 for issue_rd=0.
- Writeback to a non-busy register (e.g. a CSR-style direct write) is legal: the write happens and busy is unchanged.
- Reset mid-operation: pending busy bits and any in-flight output-stage write are dropped; regwrite goes 0 asynchronously.

Decomposition:
- Shared package holds:
  - XLEN and REG_ADDR_W constants.
  - The writeback source encoding (WB_SRC_ALU=0, WB_SRC_LSU=1).
- One natural sub-module: rr_arbiter2, a 2-requester round-robin arbiter with grant and last_grant state.
- Scoreboard and output register stay in the top module.

Test Plan:
- Reset check:
  - Stimulus: assert reset mid-cycle while regwrite=1 and busy[5]=1.
  - Required: regwrite=0 immediately; rs1_busy=0 for rs1_addr=5; after release, a tie grants wb0 first.
- Single writeback:
  - Stimulus: issue rd=5, then wb1_valid rd=5 data=0xDEADBEEF.
  - Required: wb1_ready=1 the same cycle; next cycle regwrite=1, write_reg=5, write_data=0xDEADBEEF.
  - Required: rs1_busy(5) goes 1→0 after that edge.
- Round-robin:
  - Stimulus: wb0 and wb1 both valid continuously for 4 cycles (rd=1 and rd=2).
  - Required: grants alternate 0,1,0,1; write_reg sequence 1,2,1,2 with 1-cycle latency.
- WAW block and set-wins:
  - Stimulus: issue rd=7 while busy[7]=1.
  - Required: issue_ready=0.
  - Stimulus: issue rd=7 in the cycle regwrite writes 7.
  - Required: busy[7] remains 1 afterwards.
- x0 handling:
  - Stimulus: issue rd=0, then wb0 rd=0 data=0x1234.
  - Required: issue_ready=1, busy never set, wb0_ready=1, regwrite stays 0.
- Non-busy write:
  - Stimulus: wb0 rd=9 with busy[9]=0.
  - Required: regwrite=1 to 9 next cycle; busy[9] stays 0.
